// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state encoding, opclass constants and decode result type.
package cpu_ctrl_pkg;
   typedef enum logic [3:0] {
      IDLE, PRE_IR, PRE_WR, FETCH_MAR, FETCH_IR, DECODE, ALU_WB,
      MEM_MAR, LD_MDR, LD_WB, ST_MDR, ST_WR, HALT
   } state_t;
   localparam logic OP_ALU = 1'b0;
   localparam logic [1:0] OP_LOAD = 2'b10;
   localparam logic [1:0] OP_STORE = 2'b11;
   localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
   typedef struct packed {
      logic is_halt;
      logic is_alu;
      logic is_load;
      logic is_store;
   } opclass_t;
endpackage

// File: rtl/cpu_controller_if.sv
// cpu_controller_if: controller <-> datapath control bus; master is the controller side.
interface cpu_controller_if #(parameter int WIDTH = 32);
   logic [WIDTH-1:0] irOut;
   logic start;
   logic pre_valid;
   logic [4:0] pre_reg;
   logic [WIDTH-1:0] pre_data;
   logic pre_ready;
   logic pcFetch, pcEn, irEn, marEn, ldEn, stEn, mdrEn, wr, wEn, registerFileSelect;
   logic [WIDTH-1:0] irInput;
   logic [WIDTH-1:0] dataInput;
   logic busy;
   logic halted;
   logic [15:0] retired;
   modport master (
      input irOut, start, pre_valid, pre_reg, pre_data,
      output pre_ready, pcFetch, pcEn, irEn, marEn, ldEn, stEn, mdrEn, wr, wEn,
             registerFileSelect, irInput, dataInput, busy, halted, retired
   );
   modport slave (
      output irOut, start, pre_valid, pre_reg, pre_data,
      input pre_ready, pcFetch, pcEn, irEn, marEn, ldEn, stEn, mdrEn, wr, wEn,
            registerFileSelect, irInput, dataInput, busy, halted, retired
   );
endinterface

// File: rtl/cpu_ctrl_decode.sv
// cpu_ctrl_decode: classifies the instruction register into halt/alu/load/store.
module cpu_ctrl_decode
   import cpu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] ir_i,
   output opclass_t         cls_o
);
   logic halt;
   assign halt = ir_i[31:0] == HALT_INSTR;
   always_comb begin
      cls_o.is_halt  = halt;
      cls_o.is_alu   = !halt && ir_i[31] == OP_ALU;
      cls_o.is_load  = !halt && ir_i[31:30] == OP_LOAD;
      cls_o.is_store = !halt && ir_i[31:30] == OP_STORE;
   end
endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: Moore FSM sequencing preload, fetch, decode and ALU/load/store execution.
module cpu_controller
   import cpu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic clk,
   input logic reset,
   cpu_controller_if.master bus
);
   state_t state_q, state_d;
   logic [WIDTH-1:0] ir_in_q, ir_in_d, data_in_q, data_in_d;
   logic [15:0] retired_q, retired_d;
   opclass_t cls;
   logic load_pre;
   cpu_ctrl_decode #(.WIDTH(WIDTH)) u_decode (.ir_i(bus.irOut), .cls_o(cls));
   assign load_pre = state_q == IDLE && bus.pre_valid;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         ir_in_q   <= '0;
         data_in_q <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         ir_in_q   <= ir_in_d;
         data_in_q <= data_in_d;
         retired_q <= retired_d;
      end
   end
   always_comb begin
      ir_in_d   = load_pre ? WIDTH'({6'b0, bus.pre_reg, 21'b0}) : ir_in_q;
      data_in_d = load_pre ? bus.pre_data : data_in_q;
      retired_d = retired_q + 16'(state_q inside {ALU_WB, LD_WB, ST_WR});
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      state_d = bus.pre_valid ? PRE_IR : bus.start ? FETCH_MAR : IDLE;
         PRE_IR:    state_d = PRE_WR;
         PRE_WR:    state_d = IDLE;
         FETCH_MAR: state_d = FETCH_IR;
         FETCH_IR:  state_d = DECODE;
         DECODE:    state_d = cls.is_halt ? HALT : cls.is_alu ? ALU_WB : MEM_MAR;
         ALU_WB:    state_d = FETCH_MAR;
         MEM_MAR:   state_d = cls.is_store ? ST_MDR : LD_MDR;
         LD_MDR:    state_d = LD_WB;
         LD_WB:     state_d = FETCH_MAR;
         ST_MDR:    state_d = ST_WR;
         ST_WR:     state_d = FETCH_MAR;
         HALT:      state_d = HALT;
         default:   state_d = IDLE;
      endcase
   end
   always_comb begin
      bus.pcFetch            = state_q inside {FETCH_MAR, FETCH_IR};
      bus.pcEn               = state_q == FETCH_IR;
      bus.irEn               = state_q inside {PRE_IR, FETCH_IR};
      bus.marEn              = state_q inside {FETCH_MAR, MEM_MAR};
      bus.ldEn               = state_q == LD_MDR;
      bus.stEn               = state_q == ST_MDR;
      bus.mdrEn              = state_q inside {LD_MDR, ST_MDR};
      bus.wr                 = state_q == ST_WR;
      bus.wEn                = state_q inside {PRE_WR, ALU_WB, LD_WB};
      bus.registerFileSelect = state_q == PRE_WR;
      bus.pre_ready          = state_q == PRE_WR;
      bus.busy               = !(state_q inside {IDLE, HALT});
      bus.halted             = state_q == HALT;
      bus.irInput            = ir_in_q;
      bus.dataInput          = data_in_q;
      bus.retired            = retired_q;
   end
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed + randomized checks against an instruction-level reference model.
module tb_cpu_controller;
   localparam logic [9:0] C_FMAR = 10'b1001000000;
   localparam logic [9:0] C_FIR  = 10'b1110000000;
   localparam logic [9:0] C_DEC  = 10'b0000000000;
   localparam logic [9:0] C_WB   = 10'b0000000010;
   localparam logic [9:0] C_MMAR = 10'b0001000000;
   localparam logic [9:0] C_LDM  = 10'b0000101000;
   localparam logic [9:0] C_STM  = 10'b0000011000;
   localparam logic [9:0] C_WR   = 10'b0000000100;
   localparam logic [9:0] C_PIR  = 10'b0010000000;
   localparam logic [9:0] C_PWR  = 10'b0000000011;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] exp_ret = '0;
   logic [31:0] ram [64];
   logic [31:0] ir;
   logic [5:0] pc;
   cpu_controller_if #(.WIDTH(32)) bus ();
   cpu_controller #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   assign bus.irOut = ir;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ir <= '0;
         pc <= '0;
      end else begin
         if (bus.irEn) ir <= bus.pcFetch ? ram[pc] : bus.irInput;
         if (bus.pcEn) pc <= pc + 6'd1;
      end
   end
   function automatic logic [9:0] ctl();
      return {bus.pcFetch, bus.pcEn, bus.irEn, bus.marEn, bus.ldEn, bus.stEn,
              bus.mdrEn, bus.wr, bus.wEn, bus.registerFileSelect};
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] rand_instr(input int cls);
      logic [31:0] r;
      r = $urandom;
      return cls == 0 ? {1'b0, r[30:0]} : cls == 1 ? {2'b10, r[29:0]} : {2'b11, r[29:1], 1'b0};
   endfunction
   task automatic do_reset();
      reset = 1'b1;
      bus.start = 1'b0;
      bus.pre_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_ret = '0;
   endtask
   // Expects the DUT in FETCH_MAR at a negedge; walks one instruction's control sequence.
   task automatic exec_expect(input logic [31:0] ins);
      logic [9:0] seq [$];
      bit h;
      h = ins == 32'hFFFF_FFFF;
      seq.push_back(C_FMAR);
      seq.push_back(C_FIR);
      seq.push_back(C_DEC);
      if (!h && !ins[31]) seq.push_back(C_WB);
      else if (!h) begin
         seq.push_back(C_MMAR);
         seq.push_back(ins[30] ? C_STM : C_LDM);
         seq.push_back(ins[30] ? C_WR : C_WB);
      end
      foreach (seq[i]) begin
         chk("ctl", {22'b0, ctl()}, {22'b0, seq[i]});
         chk("busy", {31'b0, bus.busy}, 32'd1);
         @(negedge clk);
         bus.start = 1'($urandom);
         bus.pre_valid = 1'($urandom);
      end
      if (h) begin
         chk("halted", {31'b0, bus.halted}, 32'd1);
         chk("halt_busy", {31'b0, bus.busy}, 32'd0);
      end else begin
         exp_ret++;
         chk("retired", {16'b0, bus.retired}, {16'b0, exp_ret});
      end
   endtask
   initial begin
      int pulses;
      logic [4:0] r;
      logic [31:0] d;
      bus.start = 1'b0;
      bus.pre_valid = 1'b0;
      bus.pre_reg = '0;
      bus.pre_data = '0;
      foreach (ram[i]) ram[i] = '0;
      repeat (2) @(negedge clk);
      chk("rst_ctl", {22'b0, ctl()}, 32'd0);
      chk("rst_flags", {29'b0, bus.pre_ready, bus.busy, bus.halted}, 32'd0);
      chk("rst_irInput", bus.irInput, 32'd0);
      chk("rst_dataInput", bus.dataInput, 32'd0);
      chk("rst_retired", {16'b0, bus.retired}, 32'd0);
      reset = 1'b0;
      bus.pre_valid = 1'b1;
      bus.pre_reg = 5'd5;
      bus.pre_data = 32'h1234;
      @(negedge clk);
      chk("pre_c1_ctl", {22'b0, ctl()}, {22'b0, C_PIR});
      chk("pre_irInput", bus.irInput, 32'h00A0_0000);
      chk("pre_dataInput", bus.dataInput, 32'h1234);
      bus.pre_valid = 1'b0;
      @(negedge clk);
      chk("pre_c2_ctl", {22'b0, ctl()}, {22'b0, C_PWR});
      chk("pre_ready", {31'b0, bus.pre_ready}, 32'd1);
      @(negedge clk);
      chk("pre_c3_ctl", {22'b0, ctl()}, 32'd0);
      chk("pre_c3_busy", {30'b0, bus.busy, bus.pre_ready}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         r = 5'($urandom);
         d = $urandom;
         bus.pre_valid = 1'b1;
         bus.pre_reg = r;
         bus.pre_data = d;
         pulses = 0;
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            pulses += int'(bus.pre_ready);
            if (c == 0) begin
               chk("rpre_irInput", bus.irInput, {6'b0, r, 21'b0});
               chk("rpre_dataInput", bus.dataInput, d);
            end
         end
         chk("rpre_pulses", pulses, 32'd1);
         chk("rpre_idle", {31'b0, bus.busy}, 32'd0);
      end
      bus.pre_valid = 1'b0;
      ram[0] = rand_instr(0);
      ram[1] = rand_instr(1);
      ram[2] = rand_instr(2);
      for (int i = 3; i < 12; i++) ram[i] = rand_instr(int'($urandom_range(0, 2)));
      ram[12] = 32'hFFFF_FFFF;
      bus.start = 1'b1;
      @(negedge clk);
      for (int i = 0; i <= 12; i++) exec_expect(ram[i]);
      for (int c = 0; c < 10; c++) begin
         bus.start = 1'($urandom);
         bus.pre_valid = 1'($urandom);
         @(negedge clk);
         chk("halt_ctl", {22'b0, ctl()}, 32'd0);
         chk("halt_flags", {29'b0, bus.pre_ready, bus.busy, bus.halted}, 32'd1);
      end
      do_reset();
      chk("post_halt_idle", {31'b0, bus.halted}, 32'd0);
      for (int i = 0; i < 8; i++) ram[i] = rand_instr(0);
      bus.start = 1'b1;
      @(negedge clk);
      exec_expect(ram[0]);
      force dut.retired_q = 16'hFFFE;
      #1;
      release dut.retired_q;
      exp_ret = 16'hFFFE;
      chk("wrap_preset", {16'b0, bus.retired}, 32'h0000_FFFE);
      exec_expect(ram[1]);
      exec_expect(ram[2]);
      chk("wrap_zero", {16'b0, bus.retired}, 32'd0);
      do_reset();
      ram[0] = rand_instr(0);
      ram[1] = rand_instr(1);
      bus.start = 1'b1;
      @(negedge clk);
      exec_expect(ram[0]);
      repeat (4) @(negedge clk);
      chk("midld_ctl", {22'b0, ctl()}, {22'b0, C_LDM});
      chk("midld_retired", {16'b0, bus.retired}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("midld_rst_ctl", {22'b0, ctl()}, 32'd0);
      chk("midld_rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("midld_rst_retired", {16'b0, bus.retired}, 32'd0);
      bus.start = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("after_rst_ctl", {22'b0, ctl()}, 32'd0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 Parameter WIDTH, default 32, datapath word width.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 irOut  in  WIDTH  current instruction register contents from the datapath.
REQ-005 start  in  1  level; in IDLE with no preload pending, begins instruction execution.
REQ-006 pre_valid  in  1  preload request for one register write.
REQ-007 pre_reg  in  5  preload destination register index.
REQ-008 pre_data  in  WIDTH  preload value.
REQ-009 pre_ready  out  1  one-cycle pulse when a preload write completes.
REQ-010 pcFetch, pcEn, irEn, marEn, ldEn, stEn, mdrEn, wr, wEn, registerFileSelect  out  1 each  datapath controls (pcFetch=1: IR from RAM, MAR from PC).
REQ-011 irInput  out  WIDTH  instruction injected into IR when pcFetch=0.
REQ-012 dataInput  out  WIDTH  register-file preload data.
REQ-013 busy  out  1  high in every state except IDLE and HALT.
REQ-014 halted  out  1  high in HALT.
REQ-015 retired  out  16  count of completed instructions.

Function
REQ-016 Moore FSM; states: IDLE, PRE_IR, PRE_WR, FETCH_MAR, FETCH_IR, DECODE, ALU_WB, MEM_MAR, LD_MDR, LD_WB, ST_MDR, ST_WR, HALT.
REQ-017 All control outputs are 0 in any state that does not assert them below.
REQ-018 IDLE: pre_valid=1 -> PRE_IR (priority over start); else start=1 -> FETCH_MAR; else stay.
REQ-019 On leaving IDLE for PRE_IR, capture irInput={6'b0,pre_reg,21'b0} and dataInput=pre_data; both hold until the next capture.
REQ-020 PRE_IR: irEn=1, pcFetch=0 -> PRE_WR.
REQ-021 PRE_WR: registerFileSelect=1, wEn=1, pre_ready=1 -> IDLE.
REQ-022 FETCH_MAR: pcFetch=1, marEn=1 -> FETCH_IR.
REQ-023 FETCH_IR: pcFetch=1, irEn=1, pcEn=1 -> DECODE; RAM read data is valid one cycle after the MAR load.
REQ-024 DECODE: irOut=32'hFFFF_FFFF -> HALT; else irOut[31]=0 -> ALU_WB; irOut[31:30]=2'b10 -> MEM_MAR (load); 2'b11 -> MEM_MAR (store).
REQ-025 ALU_WB: wEn=1, registerFileSelect=0 -> FETCH_MAR.
REQ-026 MEM_MAR: marEn=1, pcFetch=0 -> LD_MDR if irOut[30]=0, else ST_MDR.
REQ-027 LD_MDR: ldEn=1, mdrEn=1 -> LD_WB; LD_WB: wEn=1, registerFileSelect=0 -> FETCH_MAR.
REQ-028 ST_MDR: stEn=1, mdrEn=1 -> ST_WR; ST_WR: wr=1 -> FETCH_MAR.
REQ-029 ldEn and stEn are never high together; wr is never high with ldEn.
REQ-030 Cycles per instruction, FETCH_MAR to next FETCH_MAR: ALU 4, load 6, store 6.
REQ-031 retired increments by 1 on exit of ALU_WB, LD_WB and ST_WR; wraps 16'hFFFF -> 0; preloads are not counted.
REQ-032 HALT: all controls 0, halted=1; start and pre_valid are ignored; only reset exits.
REQ-033 start and pre_valid are ignored outside IDLE; pre_valid held through PRE_IR/PRE_WR yields one write per IDLE visit.

Reset
REQ-034 reset=1 forces IDLE asynchronously, regardless of the current state.
REQ-035 In IDLE after reset: all controls, pre_ready, busy and halted are 0; irInput, dataInput and retired are 0.
REQ-036 Reset asserted mid-instruction aborts it; no further wEn, wr or pcEn pulse occurs.

Structure
REQ-037 Package cpu_ctrl_pkg holds the state enumeration, the opclass constants (ALU=1'b0 at bit 31, LOAD=2'b10, STORE=2'b11) and HALT_INSTR=32'hFFFF_FFFF.
REQ-038 One sub-module, cpu_ctrl_decode, maps irOut to {is_halt, is_alu, is_load, is_store}; the FSM lives in cpu_controller.

Verification
REQ-039 Preload: reset, pre_valid=1, pre_reg=5, pre_data=32'h1234 -> irInput=32'h00A0_0000, irEn at cycle 1, wEn+registerFileSelect+pre_ready at cycle 2, back in IDLE at cycle 3.
REQ-040 ALU: start=1 with RAM[0]=ALU instruction -> marEn, then irEn+pcEn, then wEn; retired=1 four cycles after FETCH_MAR entry.
REQ-041 Load then store: ldEn+mdrEn then wEn for the load; stEn+mdrEn then wr for the store; ldEn/stEn never overlap; retired=2 after 12 cycles.
REQ-042 Halt: instruction 32'hFFFF_FFFF -> halted=1, busy=0; start and pre_valid pulses for 10 cycles produce no control activity.
REQ-043 Reset in LD_MDR -> next cycle IDLE, wEn never asserted, retired unchanged from its pre-reset value, then 0 after reset.
REQ-044 Wrap: force 65536 ALU instructions -> retired reads 0.
